pixel_frame_sequencer: RTL and testbench

Sequences a pixel-operation job over a contiguous region of frame memory: reads each pixel, streams it through the registered per-pixel datapath (brighten, darken, threshold, invert), and writes the result back in place. The block sits between the job-control logic and the frame-buffer RAM plus pixel datapath. It latches the job configuration, holds it steady for the datapath, and tracks pipeline latency so every write lands on its source address. Throughput is one pixel per clock.

---
 rtl/pixel_frame_sequencer_if.sv | 46 ++++
 rtl/pixel_frame_sequencer.sv | 114 +++++++++++
 tb/tb_pixel_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_sequencer_if.sv
// Job-control, frame-memory and pixel-datapath signals seen by the frame sequencer.
// master: the sequencer; slave: job control, frame RAM and pixel datapath.
interface pixel_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              start;
    logic              abort;
    logic [1:0]        cfg_select;
    logic [7:0]        cfg_value;
    logic [7:0]        cfg_threshold;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W:0]   cfg_len;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    logic [7:0]        pix_in;
    logic [1:0]        pix_select;
    logic [7:0]        pix_value;
    logic [7:0]        pix_threshold;
    logic [7:0]        pix_out;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W:0]   pix_count;

    modport master (
        input  start, abort, cfg_select, cfg_value, cfg_threshold, cfg_base, cfg_len,
        input  rd_data, pix_out,
        output rd_en, rd_addr, pix_in, pix_select, pix_value, pix_threshold,
        output wr_en, wr_addr, wr_data, busy, done, aborted, pix_count
    );

    modport slave (
        output start, abort, cfg_select, cfg_value, cfg_threshold, cfg_base, cfg_len,
        output rd_data, pix_out,
        input  rd_en, rd_addr, pix_in, pix_select, pix_value, pix_threshold,
        input  wr_en, wr_addr, wr_data, busy, done, aborted, pix_count
    );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Walks a frame-memory region one pixel per clock: read, pass through the
// two-cycle pixel datapath, write back to the same address.
module pixel_frame_sequencer #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pixel_frame_sequencer_if.master bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_ok, rd_fire;
    logic [ADDR_W-1:0] rd_addr_q, s1_addr_q, s2_addr_q;
    logic              s1_vld_q, s2_vld_q;
    logic [LEN_W-1:0]  remain_q, count_q;
    logic              aborted_q, busy_q, done_q;
    logic [1:0]        sel_q;
    logic [7:0]        val_q, thr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Abort masks the read in the very cycle it is seen, so rd_fire is not registered.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        rd_fire  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    state_d  = (bus.cfg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_fire = 1'b1;
                    if (remain_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            // Stage 1 empty means stage 2 empties at this edge.
            S_DRAIN: if (!s1_vld_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            s1_addr_q <= '0;
            s2_addr_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            remain_q  <= '0;
            count_q   <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= '0;
            val_q     <= '0;
            thr_q     <= '0;
        end else begin
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            s1_vld_q  <= rd_fire;
            s1_addr_q <= rd_addr_q;
            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_addr_q;
            if (start_ok) begin
                sel_q     <= bus.cfg_select;
                val_q     <= bus.cfg_value;
                thr_q     <= bus.cfg_threshold;
                rd_addr_q <= bus.cfg_base;
                remain_q  <= bus.cfg_len;
                count_q   <= '0;
                aborted_q <= 1'b0;
            end else begin
                if (rd_fire) begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    remain_q  <= remain_q - LEN_W'(1);
                end
                if (state_q == S_RUN && bus.abort) aborted_q <= 1'b1;
                if (s2_vld_q) count_q <= count_q + LEN_W'(1);
            end
        end
    end

    assign bus.rd_en         = rd_fire;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.pix_in        = bus.rd_data;
    assign bus.pix_select    = sel_q;
    assign bus.pix_value     = val_q;
    assign bus.pix_threshold = thr_q;
    assign bus.wr_en         = s2_vld_q;
    assign bus.wr_addr       = s2_addr_q;
    assign bus.wr_data       = bus.pix_out;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.pix_count     = count_q;
endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer with a frame-RAM and pixel-datapath model.
module tb_pixel_frame_sequencer;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pixel_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    pixel_frame_sequencer #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int count; logic abrt; } done_t;

    wr_t   exp_wr_q[$];
    done_t exp_done_q[$];

    logic [7:0] ram     [DEPTH];
    bit         ram_vld [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    bit         ref_vld [DEPTH];

    logic        pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    int n_checks = 0;
    int n_errors = 0;
    int rd_total = 0;
    logic [1:0] exp_sel;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        logic [15:0] h;
        h = a * 16'd97 + 16'd13;
        return h[10:3] ^ a[15:8];
    endfunction

    function automatic logic [7:0] pix_op(input logic [7:0] p, input logic [1:0] s,
                                          input logic [7:0] v, input logic [7:0] t);
        int r;
        case (s)
            2'd0:    r = (int'(p) + int'(v) > 255) ? 255 : int'(p) + int'(v);
            2'd1:    r = (p < v) ? 0 : int'(p) - int'(v);
            2'd2:    r = (p >= t) ? 255 : 0;
            default: r = 255 - int'(p);
        endcase
        return 8'(r);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_vld[a] ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame RAM (one-cycle read) and registered pixel datapath.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr]     <= pre_data;
            ram_vld[pre_addr] <= 1'b1;
        end
        if (bus.rd_en)
            bus.rd_data <= ram_vld[bus.rd_addr] ? ram[bus.rd_addr] : init_byte(bus.rd_addr);
        if (bus.wr_en) begin
            ram[bus.wr_addr]     <= bus.wr_data;
            ram_vld[bus.wr_addr] <= 1'b1;
        end
        bus.pix_out <= pix_op(bus.pix_in, bus.pix_select, bus.pix_value, bus.pix_threshold);
    end

    // Monitor: pops expected writes and job completions.
    always @(negedge clk) begin
        wr_t   e;
        done_t d;
        if (bus.rd_en === 1'b1) rd_total++;
        if (bus.wr_en === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_wr_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                chk("pix_select_hold", 32'(bus.pix_select), 32'(exp_sel));
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_done: got done=1, required 0");
            end else begin
                d = exp_done_q.pop_front();
                chk("pix_count", 32'(bus.pix_count), 32'(d.count));
                chk("aborted_at_done", 32'(bus.aborted), 32'(d.abrt));
                chk("writes_drained", 32'(exp_wr_q.size()), 32'd0);
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        ref_vld[a] = 1'b1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"},     32'(bus.rd_en), 32'd0);
        chk({tag, "_wr_en"},     32'(bus.wr_en), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy), 32'd0);
        chk({tag, "_done"},      32'(bus.done), 32'd0);
        chk({tag, "_aborted"},   32'(bus.aborted), 32'd0);
        chk({tag, "_pix_count"}, 32'(bus.pix_count), 32'd0);
        chk({tag, "_addrs"},     {bus.rd_addr, bus.wr_addr}, 32'd0);
        chk({tag, "_cfg"},       32'({bus.pix_select, bus.pix_value, bus.pix_threshold}), 32'd0);
    endtask

    task automatic run_job(input logic [15:0] base, input int len, input logic [1:0] sel,
                           input logic [7:0] val, input logic [7:0] thr,
                           input int abort_cyc, input int rst_cyc);
        int   n_rd, n_wr, exp_done, done_cyc, rd0;
        logic aborting;
        logic [15:0] a;
        logic [7:0]  d;
        aborting = (abort_cyc > 0 && abort_cyc <= len);
        n_rd = aborting ? abort_cyc - 1 : len;
        n_wr = n_rd;
        if (rst_cyc > 0 && rst_cyc - 2 < n_wr) n_wr = (rst_cyc > 2) ? rst_cyc - 2 : 0;
        exp_done = (len == 0) ? 1 : (aborting ? abort_cyc + 2 : len + 3);

        for (int i = 0; i < n_wr; i++) begin
            a = base + 16'(i);
            d = pix_op(ref_rd(a), sel, val, thr);
            exp_wr_q.push_back('{a, d});
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
        if (rst_cyc == 0) exp_done_q.push_back('{n_wr, aborting});
        exp_sel = sel;

        bus.cfg_select = sel; bus.cfg_value = val; bus.cfg_threshold = thr;
        bus.cfg_base = base; bus.cfg_len = 17'(len);
        bus.start = 1'b1;
        rd0 = rd_total;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.cfg_select = ~sel; bus.cfg_value = 8'($urandom); bus.cfg_threshold = 8'($urandom);
        bus.cfg_base = 16'($urandom); bus.cfg_len = 17'($urandom_range(0, 50));

        done_cyc = 0;
        for (int c = 1; c <= len + 8 && done_cyc == 0; c++) begin
            bus.abort = (c == abort_cyc);
            bus.start = (c == 2 && len > 0);
            if (c == rst_cyc) rst_n = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                chk("busy_cycle1", 32'(bus.busy), 32'd1);
                chk("rd_en_cycle1", 32'(bus.rd_en), 32'(n_rd > 0));
                if (len > 0) chk("first_rd_addr", 32'(bus.rd_addr), 32'(base));
                chk("pix_cfg_latched", 32'({bus.pix_select, bus.pix_value, bus.pix_threshold}),
                    32'({sel, val, thr}));
            end
            if (bus.done === 1'b1) begin
                done_cyc = c;
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
            @(posedge clk); #1;
            if (c == rst_cyc) begin
                rst_n = 1'b1;
                bus.start = 1'b0; bus.abort = 1'b0;
                @(negedge clk);
                check_zero("mid_reset");
                repeat (4) @(posedge clk);
                #1;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        if (rst_cyc == 0) begin
            if (done_cyc == 0) begin
                n_checks++; n_errors++;
                $display("FAIL done_timeout: no done within %0d cycles, required cycle %0d", len + 8, exp_done);
            end else begin
                chk("done_cycle", 32'(done_cyc), 32'(exp_done));
            end
            @(negedge clk);
            chk("busy_after_done", 32'(bus.busy), 32'd0);
            chk("aborted_hold", 32'(bus.aborted), 32'(aborting));
            chk("rd_count", 32'(rd_total - rd0), 32'(n_rd));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int len, ab;
        rst_n = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.cfg_select = 2'd1; bus.cfg_value = 8'h5; bus.cfg_threshold = 8'h7;
        bus.cfg_base = 16'h1234; bus.cfg_len = 17'd9;
        exp_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(16'h0010, 8'h00); preload(16'h0011, 8'h10);
        preload(16'h0012, 8'h80); preload(16'h0013, 8'hFF);
        run_job(16'h0010, 4, 2'b11, 8'h00, 8'h00, 0, 0);

        preload(16'hFFFE, 8'hF0); preload(16'hFFFF, 8'h10); preload(16'h0000, 8'hE0);
        run_job(16'hFFFE, 3, 2'b00, 8'h20, 8'h00, 0, 0);

        run_job(16'h1000, 100, 2'b10, 8'h00, 8'h80, 10, 0);
        run_job(16'h0400, 0, 2'b01, 8'h11, 8'h22, 0, 0);
        run_job(16'h2000, 20, 2'b01, 8'h33, 8'h00, 0, 5);
        run_job(16'h2100, 6, 2'b10, 8'h00, 8'h40, 0, 0);

        for (int j = 0; j < 40; j++) begin
            len = int'($urandom_range(0, 40));
            ab  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + 3)) : 0;
            run_job(16'($urandom), len, 2'($urandom), 8'($urandom), 8'($urandom), ab, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
